rast_tri_arbiter: RTL and testbench

- Front-end scheduler for rast_magma.
- Round-robin arbitrates among NUM_REQ triangle sources and drives the rasterizer triangle input (tri_R10S/color_R10U/validTri_R10H) through one output register, honouring halt_RnnnnL back-pressure.
- Owns the screen/subsample configuration registers: a config update is applied only after the rasterizer pipeline has drained, so no in-flight triangle sees mixed configuration.

---
 rtl/rast_tri_arbiter_pkg.sv | 42 ++++
 rtl/rast_tri_arbiter_if.sv | 38 +++
 rtl/rast_tri_arbiter_rr_arbiter.sv | 54 +++++
 rtl/rast_tri_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rast_tri_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rast_tri_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rast_tri_arbiter_pkg
// Shared constants, types and helpers for the rasterizer front-end arbiter.
//   - Geometry/precision constants (SIGFIG, VERTS, AXIS, COLORS)
//   - Rasterizer pipeline depths used to size the drain window
//   - Arbiter FSM state type and the triangle payload struct
//   - rr_wrap(): modulo helper for round-robin index arithmetic
// ----------------------------------------------------------------------------
package rast_tri_arbiter_pkg;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    // Pipeline depths of the downstream rasterizer stages.
    localparam int PIPES_BOX  = 3;
    localparam int PIPES_ITER = 1;
    localparam int PIPES_HASH = 1;
    localparam int PIPES_SAMP = 2;

    localparam int NUM_REQ_DEF      = 4;
    // Idle cycles after which no triangle can still be inside the rasterizer.
    localparam int DRAIN_CYCLES_DEF = PIPES_BOX + PIPES_ITER + PIPES_HASH + PIPES_SAMP + 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_s;
        logic [COLORS-1:0][SIGFIG-1:0]          color_u;
    } tri_payload_t;

    // (base + step) mod n, for walking the round-robin ring.
    function automatic int rr_wrap(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/rast_tri_arbiter_if.sv
// ----------------------------------------------------------------------------
// rast_tri_arbiter_if
// Triangle handshake bundle: the per-requester request side (R9) and the
// registered rasterizer side (R10) including the rasterizer ready/halt.
//   master : requesters + rasterizer (drive requests and halt)
//   slave  : the arbiter (drives grants and the output register)
// ----------------------------------------------------------------------------
interface rast_tri_arbiter_if
    import rast_tri_arbiter_pkg::*;
#(
    parameter int SIGFIG_P  = SIGFIG,
    parameter int VERTS_P   = VERTS,
    parameter int AXIS_P    = AXIS,
    parameter int COLORS_P  = COLORS,
    parameter int NUM_REQ_P = NUM_REQ_DEF
);

    logic [NUM_REQ_P-1:0][VERTS_P-1:0][AXIS_P-1:0][SIGFIG_P-1:0] req_tri_R9S;
    logic [NUM_REQ_P-1:0][COLORS_P-1:0][SIGFIG_P-1:0]            req_color_R9U;
    logic [NUM_REQ_P-1:0]                                        req_valid_R9H;
    logic [NUM_REQ_P-1:0]                                        req_ready_R9H;

    logic [VERTS_P-1:0][AXIS_P-1:0][SIGFIG_P-1:0] tri_R10S;
    logic [COLORS_P-1:0][SIGFIG_P-1:0]            color_R10U;
    logic                                         validTri_R10H;
    logic                                         halt_RnnnnL;

    modport master (
        output req_tri_R9S, req_color_R9U, req_valid_R9H, halt_RnnnnL,
        input  req_ready_R9H, tri_R10S, color_R10U, validTri_R10H
    );

    modport slave (
        input  req_tri_R9S, req_color_R9U, req_valid_R9H, halt_RnnnnL,
        output req_ready_R9H, tri_R10S, color_R10U, validTri_R10H
    );

endinterface

// File: rtl/rast_tri_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rast_tri_arbiter_rr_arbiter
// Combinational round-robin picker. Searches req starting at ptr+1 (mod
// NUM_REQ) and returns the first set request.
//   req         : request vector
//   ptr         : index of the last granted requester
//   en          : grants allowed this cycle
//   grant       : one-hot grant (zero when en=0 or no request)
//   grant_idx   : index of the granted requester (ptr when none)
//   grant_valid : a grant is given
// ----------------------------------------------------------------------------
module rast_tri_arbiter_rr_arbiter
    import rast_tri_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Candidate gi is the requester gi+1 positions after the pointer, so
    // candidate 0 has the highest priority.
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'(rr_wrap(int'(ptr), gi + 1, NUM_REQ));
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_idx   = ptr;
        grant_valid = 1'b0;
        // Walk from lowest priority to highest so the last hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (en && cand_req[k]) begin
                grant_idx   = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rast_tri_arbiter.sv
// ----------------------------------------------------------------------------
// rast_tri_arbiter
// Front-end scheduler for the rasterizer: round-robin picks one of NUM_REQ
// triangle sources into a single output register honouring halt_RnnnnL, and
// owns the screen/subsample configuration, which is only changed once the
// rasterizer has been idle for DRAIN_CYCLES cycles.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : requester handshake and rasterizer triangle output
//   cfg_screen_in     : new screen dimensions
//   cfg_subSample_in  : new subsample interval
//   cfg_update_H      : one-cycle request to change configuration
//   screen_RnnnnS     : applied screen dimensions
//   subSample_RnnnnU  : applied subsample interval
//   cfg_busy_H        : a configuration change is pending
//   tri_count_U       : triangles accepted by the rasterizer (wraps)
// ----------------------------------------------------------------------------
module rast_tri_arbiter
    import rast_tri_arbiter_pkg::*;
#(
    parameter int SIGFIG       = rast_tri_arbiter_pkg::SIGFIG,
    parameter int VERTS        = rast_tri_arbiter_pkg::VERTS,
    parameter int AXIS         = rast_tri_arbiter_pkg::AXIS,
    parameter int COLORS       = rast_tri_arbiter_pkg::COLORS,
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [1:0][SIGFIG-1:0] SCREEN_RST = {SIGFIG'(2048), SIGFIG'(2048)},
    parameter logic [3:0] SUBSAMPLE_RST = 4'b1000
) (
    input  logic                   clk,
    input  logic                   rst,
    rast_tri_arbiter_if.slave      bus,
    input  logic [1:0][SIGFIG-1:0] cfg_screen_in,
    input  logic [3:0]             cfg_subSample_in,
    input  logic                   cfg_update_H,
    output logic [1:0][SIGFIG-1:0] screen_RnnnnS,
    output logic [3:0]             subSample_RnnnnU,
    output logic                   cfg_busy_H,
    output logic [31:0]            tri_count_U
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef struct packed {
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_s;
        logic [COLORS-1:0][SIGFIG-1:0]          color_u;
    } payload_t;

    arb_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       idle_cnt_reg, idle_cnt_next;
    logic                   apply_en;

    logic                   valid_reg;
    payload_t               payload_reg;
    logic [IDX_W-1:0]       ptr_reg;
    logic [31:0]            tri_count_reg;

    logic [1:0][SIGFIG-1:0] screen_reg, pend_screen_reg;
    logic [3:0]             subsample_reg, pend_subsample_reg;
    logic                   cfg_busy_reg;

    logic                   free;
    logic                   accept;
    logic                   grant_en;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;

    // The output register can take a new triangle when it is empty or its
    // current triangle is being accepted this cycle.
    assign free     = !valid_reg || bus.halt_RnnnnL;
    assign accept   = valid_reg && bus.halt_RnnnnL;
    assign grant_en = (state_reg == RUN) && free;

    rast_tri_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (bus.req_valid_R9H),
        .ptr         (ptr_reg),
        .en          (grant_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready_R9H = grant;
    assign bus.validTri_R10H = valid_reg;
    assign bus.tri_R10S      = payload_reg.tri_s;
    assign bus.color_R10U    = payload_reg.color_u;

    assign screen_RnnnnS     = screen_reg;
    assign subSample_RnnnnU  = subsample_reg;
    assign cfg_busy_H        = cfg_busy_reg;
    assign tri_count_U       = tri_count_reg;

    // ------------------------------------------------------------------
    // Triangle datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            payload_reg   <= '0;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            tri_count_reg <= '0;
        end else begin
            if (accept) begin
                tri_count_reg <= tri_count_reg + 32'd1;
            end
            // A grant only goes to a valid requester, so grant == handshake.
            if (grant_valid) begin
                payload_reg <= '{tri_s:   bus.req_tri_R9S[grant_idx],
                                 color_u: bus.req_color_R9U[grant_idx]};
                valid_reg   <= 1'b1;
                ptr_reg     <= grant_idx;
            end else if (free) begin
                valid_reg   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = '0;
        apply_en      = 1'b0;
        case (state_reg)
            RUN: begin
                if (cfg_update_H) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                idle_cnt_next = idle_cnt_reg;
                // Any halt means the rasterizer still holds work: restart.
                if (!bus.halt_RnnnnL) begin
                    idle_cnt_next = '0;
                end else if (!valid_reg) begin
                    if (idle_cnt_reg == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_next    = APPLY;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
            end
            APPLY: begin
                apply_en   = 1'b1;
                // A request landing in APPLY needs its own full drain.
                state_next = cfg_update_H ? DRAIN : RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= RUN;
            idle_cnt_reg       <= '0;
            cfg_busy_reg       <= 1'b0;
            screen_reg         <= SCREEN_RST;
            subsample_reg      <= SUBSAMPLE_RST;
            pend_screen_reg    <= SCREEN_RST;
            pend_subsample_reg <= SUBSAMPLE_RST;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            cfg_busy_reg <= (state_next != RUN);
            // Applied values come from the pending set as it stood before
            // any capture in the same cycle.
            if (apply_en) begin
                screen_reg    <= pend_screen_reg;
                subsample_reg <= pend_subsample_reg;
            end
            if (cfg_update_H) begin
                pend_screen_reg    <= cfg_screen_in;
                pend_subsample_reg <= cfg_subSample_in;
            end
        end
    end

endmodule

// File: tb/tb_rast_tri_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rast_tri_arbiter
// Randomized and directed stimulus for rast_tri_arbiter, checked every cycle
// against a cycle-level behavioural model of the scheduling and config rules.
// ----------------------------------------------------------------------------
module tb_rast_tri_arbiter;
    import rast_tri_arbiter_pkg::*;

    localparam int N     = NUM_REQ_DEF;
    localparam int DRAIN_N = DRAIN_CYCLES_DEF;
    localparam int M_RUN = 0, M_DRAIN = 1, M_APPLY = 2;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
    typedef logic [1:0][SIGFIG-1:0]                 scr_t;

    logic        clk = 1'b0;
    logic        rst;
    scr_t        cfg_screen_in;
    logic [3:0]  cfg_subSample_in;
    logic        cfg_update_H;
    scr_t        screen_RnnnnS;
    logic [3:0]  subSample_RnnnnU;
    logic        cfg_busy_H;
    logic [31:0] tri_count_U;

    always #5 clk = ~clk;

    rast_tri_arbiter_if bus ();

    rast_tri_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cfg_screen_in    (cfg_screen_in),
        .cfg_subSample_in (cfg_subSample_in),
        .cfg_update_H     (cfg_update_H),
        .screen_RnnnnS    (screen_RnnnnS),
        .subSample_RnnnnU (subSample_RnnnnU),
        .cfg_busy_H       (cfg_busy_H),
        .tri_count_U      (tri_count_U)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Stimulus copies and reference model state
    tri_t        s_tri [N];
    col_t        s_col [N];
    int          m_ptr, m_mode, m_idle;
    bit          m_valid;
    tri_t        m_tri;
    col_t        m_col;
    scr_t        m_scr, m_pscr;
    logic [3:0]  m_ss, m_pss;
    bit          m_busy;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_mode  = M_RUN;
        m_idle  = 0;
        m_valid = 1'b0;
        m_tri   = '0;
        m_col   = '0;
        m_scr   = {SIGFIG'(2048), SIGFIG'(2048)};
        m_ss    = 4'b1000;
        m_pscr  = m_scr;
        m_pss   = m_ss;
        m_busy  = 1'b0;
        m_count = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model by the rules for this cycle's inputs.
    task automatic step(input logic [N-1:0] v, input logic h, input logic upd,
                        input scr_t scr, input logic [3:0] ss, input logic r);
        int          g;
        int          idx;
        bit          free;
        bit          was_valid;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < VERTS; a++)
                for (int b = 0; b < AXIS; b++)
                    s_tri[i][a][b] = SIGFIG'($urandom);
            for (int c = 0; c < COLORS; c++)
                s_col[i][c] = SIGFIG'($urandom);
            bus.req_tri_R9S[i]   = s_tri[i];
            bus.req_color_R9U[i] = s_col[i];
        end
        bus.req_valid_R9H = v;
        bus.halt_RnnnnL   = h;
        cfg_update_H      = upd;
        cfg_screen_in     = scr;
        cfg_subSample_in  = ss;
        rst               = r;
        #1;
        free = !m_valid || h;
        g = -1;
        if (m_mode == M_RUN && free) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready_R9H, exp_ready);
        check("validTri", bus.validTri_R10H, m_valid);
        check("tri", bus.tri_R10S, m_tri);
        check("color", bus.color_R10U, m_col);
        check("screen", screen_RnnnnS, m_scr);
        check("subSample", subSample_RnnnnU, m_ss);
        check("cfg_busy", cfg_busy_H, m_busy);
        check("tri_count", tri_count_U, m_count);

        if (r) begin
            $display("cycle %0d: reset", cyc);
            model_reset();
        end else begin
            was_valid = m_valid;
            if (m_valid && h) m_count++;
            if (g >= 0) begin
                m_tri   = s_tri[g];
                m_col   = s_col[g];
                m_valid = 1'b1;
                m_ptr   = g;
                $display("cycle %0d: grant req %0d, accepted so far %0d", cyc, g, m_count);
            end else if (free) begin
                m_valid = 1'b0;
            end
            case (m_mode)
                M_RUN: if (upd) begin
                    m_pscr = scr; m_pss = ss; m_mode = M_DRAIN; m_idle = 0;
                end
                M_DRAIN: begin
                    if (upd) begin m_pscr = scr; m_pss = ss; end
                    if (!h) m_idle = 0;
                    else if (!was_valid) begin
                        m_idle++;
                        if (m_idle == DRAIN_N) begin m_mode = M_APPLY; m_idle = 0; end
                    end
                end
                default: begin
                    m_scr = m_pscr; m_ss = m_pss;
                    if (upd) begin m_pscr = scr; m_pss = ss; m_mode = M_DRAIN; m_idle = 0; end
                    else m_mode = M_RUN;
                end
            endcase
            m_busy = (m_mode != M_RUN);
        end
        cyc++;
    endtask

    scr_t s_none, s_a, s_b;
    int   guard;

    initial begin
        s_none = {SIGFIG'(0), SIGFIG'(0)};
        s_a    = {SIGFIG'(1024), SIGFIG'(768)};
        s_b    = {SIGFIG'(640), SIGFIG'(480)};
        rst = 1'b1;
        bus.req_valid_R9H = '0;
        bus.halt_RnnnnL   = 1'b1;
        bus.req_tri_R9S   = '0;
        bus.req_color_R9U = '0;
        cfg_update_H      = 1'b0;
        cfg_screen_in     = s_none;
        cfg_subSample_in  = 4'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // All requesters valid, no back-pressure: 0,1,2,3,0 then drain
        repeat (5) step(4'b1111, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, s_none, 4'h0, 1'b0);

        // Held triangle under halt, requester 2 waiting
        step(4'b0001, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        repeat (6) step(4'b0100, 1'b0, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, s_none, 4'h0, 1'b0);

        // Single requester, then a second joins mid-stream
        repeat (3) step(4'b0010, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        repeat (4) step(4'b1010, 1'b1, 1'b0, s_none, 4'h0, 1'b0);

        // Config update while streaming, halt glitch mid-count, second update
        step(4'b1111, 1'b1, 1'b1, s_a, 4'b0100, 1'b0);
        repeat (3) step(4'b1111, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        repeat (5) step(4'b1111, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b1111, 1'b1, 1'b1, s_b, 4'b0010, 1'b0);
        repeat (DRAIN_N + 6) step(4'b1111, 1'b1, 1'b0, s_none, 4'h0, 1'b0);

        // Update landing exactly in the APPLY cycle
        step(4'b0000, 1'b1, 1'b1, s_a, 4'b0100, 1'b0);
        guard = 0;
        while (m_mode != M_APPLY && guard < 100) begin
            step(4'b0000, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
            guard++;
        end
        step(4'b0000, 1'b1, 1'b1, s_b, 4'b0001, 1'b0);
        repeat (DRAIN_N + 4) step(4'b0101, 1'b1, 1'b0, s_none, 4'h0, 1'b0);

        // Reset while holding a triangle under halt and draining
        step(4'b1111, 1'b1, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, s_a, 4'b0100, 1'b0);
        step(4'b1111, 1'b0, 1'b0, s_none, 4'h0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, s_none, 4'h0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, s_none, 4'h0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            step(N'($urandom), ($urandom_range(99, 0) < 75),
                 ($urandom_range(99, 0) < 3),
                 {SIGFIG'($urandom_range(4095, 1)), SIGFIG'($urandom_range(4095, 1))},
                 4'($urandom), ($urandom_range(999, 0) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
